// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the console UART receive path: register addresses,
// line-status bit positions and the empty-read marker.
package uart_rx_fifo_pkg;

    localparam logic [31:0] RX_ADDR_DEFAULT  = 32'h1000_0000;
    localparam logic [31:0] LSR_ADDR_DEFAULT = 32'h1000_0005;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam logic [31:0] EMPTY_MARKER = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter; a pop in the same cycle lets
// a push into a full FIFO succeed.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic                       push_drop,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[head_q];
    assign count = count_q;

    always_comb begin
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
        push_drop = push && !push_ok;
        head_d    = pop_ok  ? head_q + PW'(1) : head_q;
        tail_d    = push_ok ? tail_q + PW'(1) : tail_q;
        count_d   = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered UART receive path: captures bytes into a FIFO and serves the RX
// data and line-status registers on the CPU bus.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] RX_ADDR   = RX_ADDR_DEFAULT,
    parameter logic [31:0] LSR_ADDR  = LSR_ADDR_DEFAULT,
    parameter int          IRQ_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   rx_frame_err,
    input  logic                   mem_valid,
    input  logic [31:0]            mem_addr,
    input  logic [3:0]             mem_wstrb,
    output logic                   mem_ready,
    output logic [31:0]            mem_rdata,
    output logic                   rx_irq,
    output logic [$clog2(DEPTH):0] level
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        overrun_q, overrun_d;
    logic        ferr_q, ferr_d;

    logic        hit, is_write, rx_rd, lsr_rd;
    logic        push, pop;
    logic [7:0]  head_byte;
    logic        fifo_full, fifo_empty, push_drop;
    logic [7:0]  lsr;

    // Bus handshake: a request is taken when mem_valid is high and no ready
    // is outstanding; mem_ready pulses for exactly one cycle the cycle after,
    // with mem_rdata valid alongside it. Other addresses never get a ready.
    assign hit      = mem_valid && !ready_q && (mem_addr == RX_ADDR || mem_addr == LSR_ADDR);
    assign is_write = |mem_wstrb;
    assign rx_rd    = hit && !is_write && (mem_addr == RX_ADDR);
    assign lsr_rd   = hit && !is_write && (mem_addr == LSR_ADDR);
    assign push     = rx_valid && !rx_frame_err;
    assign pop      = rx_rd && !fifo_empty;

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wdata     (rx_data),
        .pop       (pop),
        .rdata     (head_byte),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (push_drop),
        .count     (level)
    );

    assign rx_irq = (level >= CW'(IRQ_LEVEL));

    always_comb begin
        lsr           = '0;
        lsr[LSR_DR]   = !fifo_empty;
        lsr[LSR_OE]   = overrun_q;
        lsr[LSR_FE]   = ferr_q;

        ready_d = hit;
        rdata_d = '0;
        if (rx_rd) begin
            rdata_d = fifo_empty ? EMPTY_MARKER : {24'b0, head_byte};
        end else if (lsr_rd) begin
            rdata_d = {16'b0, lsr, 8'b0};
        end

        // Set events take priority over the clearing LSR read.
        overrun_d = lsr_rd ? 1'b0 : overrun_q;
        if (push_drop) begin
            overrun_d = 1'b1;
        end
        ferr_d = lsr_rd ? 1'b0 : ferr_q;
        if (rx_valid && rx_frame_err) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: register reads, FIFO ordering, overrun,
// frame error, held requests and mid-stream reset.
module tb_uart_rx_fifo;
    localparam logic [31:0] RX  = 32'h1000_0000;
    localparam logic [31:0] LSR = 32'h1000_0005;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        rx_irq;
    logic [4:0]  level;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    uart_rx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .rx_irq       (rx_irq),
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic fe);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b; rx_frame_err = fe;
        @(negedge clk);
        rx_valid = 1'b0; rx_frame_err = 1'b0;
    endtask

    // One-cycle bus request; samples ready/rdata on the following negedge.
    task automatic bus_req(input logic [31:0] addr, input logic [3:0] strb,
                           output logic rdy, output logic [31:0] data);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = addr; mem_wstrb = strb;
        @(negedge clk);
        rdy = mem_ready; data = mem_rdata;
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic        rdy;
        logic [31:0] d;
        bus_req(addr, 4'h0, rdy, d);
        check({tag, "_ready"}, {31'b0, rdy}, 32'd1);
        check(tag, d, exp);
    endtask

    task automatic drain_chk(input string tag, input int n);
        logic        rdy;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            bus_req(RX, 4'h0, rdy, d);
            check({tag, "_ready"}, {31'b0, rdy}, 32'd1);
            if (exp_q.size() == 0) check({tag, "_underflow"}, d, 32'hDEAD_BEEF);
            else check(tag, d, exp_q.pop_front());
        end
    endtask

    initial begin
        logic        rdy;
        logic [31:0] d;
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_frame_err = 1'b0;
        mem_valid = 1'b0; mem_addr = '0; mem_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_irq",   {31'b0, rx_irq}, 32'd0);
        check("rst_level", {27'b0, level}, 32'd0);
        reset = 1'b0;

        // Empty FIFO reads
        read_chk("lsr_empty", LSR, 32'h0000_0000);
        read_chk("rx_empty",  RX,  32'hFFFF_FFFF);
        check("rx_empty_level", {27'b0, level}, 32'd0);

        // Ordering and interrupt
        push_byte(8'h41, 1'b0);
        check("irq_after_push", {31'b0, rx_irq}, 32'd1);
        push_byte(8'h42, 1'b0);
        push_byte(8'h43, 1'b0);
        check("level3", {27'b0, level}, 32'd3);
        read_chk("rd41", RX, 32'h41);
        read_chk("rd42", RX, 32'h42);
        read_chk("rd43", RX, 32'h43);
        check("irq_after_pop", {31'b0, rx_irq}, 32'd0);
        check("level0", {27'b0, level}, 32'd0);

        // Overrun: 17th byte dropped
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h10 + 8'(i), 1'b0);
            if (i < 16) exp_q.push_back(32'h10 + 32'(i));
        end
        check("full_level", {27'b0, level}, 32'd16);
        read_chk("lsr_overrun", LSR, 32'h0000_0300);
        read_chk("lsr_cleared", LSR, 32'h0000_0100);
        drain_chk("ovr_data", 16);
        check("ovr_drained", {27'b0, level}, 32'd0);

        // Push into a full FIFO together with a pop
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h60 + 8'(i), 1'b0);
            if (i > 0) exp_q.push_back(32'h60 + 32'(i));
        end
        exp_q.push_back(32'h99);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h99;
        mem_valid = 1'b1; mem_addr = RX; mem_wstrb = 4'h0;
        @(negedge clk);
        check("fullpop_ready", {31'b0, mem_ready}, 32'd1);
        check("fullpop_data",  mem_rdata, 32'h60);
        rx_valid = 1'b0; mem_valid = 1'b0;
        check("fullpop_level", {27'b0, level}, 32'd16);
        read_chk("fullpop_lsr", LSR, 32'h0000_0100);
        drain_chk("fullpop_drain", 16);

        // Frame error
        push_byte(8'h55, 1'b1);
        check("ferr_level", {27'b0, level}, 32'd0);
        read_chk("lsr_ferr", LSR, 32'h0000_0800);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h55; rx_frame_err = 1'b1;
        mem_valid = 1'b1; mem_addr = LSR;
        @(negedge clk);
        check("ferr_race_rd", mem_rdata, 32'h0000_0000);
        rx_valid = 1'b0; rx_frame_err = 1'b0; mem_valid = 1'b0;
        read_chk("ferr_race_next", LSR, 32'h0000_0800);

        // Writes and unmapped addresses
        push_byte(8'hA1, 1'b0);
        push_byte(8'hA2, 1'b0);
        bus_req(RX, 4'hF, rdy, d);
        check("write_ready", {31'b0, rdy}, 32'd1);
        check("write_level", {27'b0, level}, 32'd2);
        bus_req(32'h1000_0004, 4'h0, rdy, d);
        check("unmapped_ready", {31'b0, rdy}, 32'd0);

        // mem_valid held for three cycles: pop, gap, pop
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = RX; mem_wstrb = 4'h0;
        @(negedge clk);
        check("hold_c1_ready", {31'b0, mem_ready}, 32'd1);
        check("hold_c1_data",  mem_rdata, 32'hA1);
        @(negedge clk);
        check("hold_c2_ready", {31'b0, mem_ready}, 32'd0);
        check("hold_c2_level", {27'b0, level}, 32'd1);
        @(negedge clk);
        check("hold_c3_ready", {31'b0, mem_ready}, 32'd1);
        check("hold_c3_data",  mem_rdata, 32'hA2);
        mem_valid = 1'b0;

        // Reset while a ready is pending
        push_byte(8'hB1, 1'b0);
        push_byte(8'hB2, 1'b0);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = RX;
        @(negedge clk);
        check("prerst_ready", {31'b0, mem_ready}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'b0, mem_ready}, 32'd0);
        check("midrst_level", {27'b0, level}, 32'd0);
        check("midrst_irq",   {31'b0, rx_irq}, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        read_chk("postrst_rx", RX, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
